// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR vote monitor and its per-replica trackers.
package tmr_pkg;

    typedef enum logic [1:0] {
        RS_OK      = 2'd0,
        RS_SUSPECT = 2'd1,
        RS_FAILED  = 2'd2
    } replica_state_t;

    localparam int unsigned REPLICAS = 3;

    // Run counter must be able to hold the value THRESH itself
    function automatic int unsigned run_width(input int unsigned thresh);
        return $clog2(thresh + 1);
    endfunction

endpackage

// File: rtl/tmr_replica_tracker.sv
// Health tracker for one replica: OK/SUSPECT/FAILED state, consecutive-fault run
// counter and a saturating lifetime error counter.
module tmr_replica_tracker
    import tmr_pkg::*;
#(
    parameter int unsigned THRESH = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             vote_en,
    input  logic             err,
    input  logic             ack,
    input  logic             cnt_clr,
    output logic             failed,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned RUN_W = run_width(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    replica_state_t   state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             failed_q;

    // State, run and lifetime counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= RS_OK;
            run_q    <= '0;
            cnt_q    <= '0;
            failed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            failed_q <= (state_d == RS_FAILED);
        end
    end

    // Next-state: FAILED is sticky until an accepted acknowledge
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        run_inc = run_q + RUN_W'(1);

        case (state_q)
            RS_OK: begin
                if (vote_en && err) begin
                    run_d   = RUN_W'(1);
                    state_d = (THRESH == 1) ? RS_FAILED : RS_SUSPECT;
                end
            end
            RS_SUSPECT: begin
                if (vote_en) begin
                    if (err) begin
                        run_d = run_inc;
                        if (run_inc == RUN_W'(THRESH)) begin
                            state_d = RS_FAILED;
                        end
                    end else begin
                        run_d   = '0;
                        state_d = RS_OK;
                    end
                end
            end
            RS_FAILED: begin
                if (ack) begin
                    run_d   = '0;
                    state_d = RS_OK;
                end
            end
            default: begin
                run_d   = '0;
                state_d = RS_OK;
            end
        endcase

        // Clear takes priority over a same-cycle increment
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (vote_en && err && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign failed  = failed_q;
    assign err_cnt = cnt_q;

endmodule

// File: rtl/tmr_vote_monitor.sv
// Registered TMR word voter with per-replica fault tracking and a resync
// request/acknowledge handshake towards the core recovery logic.
module tmr_vote_monitor
    import tmr_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned THRESH = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_a,
    input  logic [WIDTH-1:0]          in_b,
    input  logic [WIDTH-1:0]          in_c,
    input  logic [REPLICAS-1:0]       err_inject,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_word,
    output logic [REPLICAS-1:0]       out_err,
    output logic                      out_uncorr,
    output logic [REPLICAS-1:0]       failed,
    output logic                      resync_req,
    input  logic                      resync_ack,
    input  logic                      cnt_clr,
    output logic [REPLICAS*CNT_W-1:0] err_cnt,
    output logic                      sticky_uncorr
);

    logic [WIDTH-1:0]    rep_a, rep_b, rep_c;
    logic                m_ab, m_ac, m_bc;
    logic [WIDTH-1:0]    vote_word;
    logic [REPLICAS-1:0] vote_err;
    logic                vote_uncorr;
    logic                ack_eff;

    // Fault injection then pairwise compare and majority select
    always_comb begin
        rep_a       = in_a ^ {WIDTH{err_inject[0]}};
        rep_b       = in_b ^ {WIDTH{err_inject[1]}};
        rep_c       = in_c ^ {WIDTH{err_inject[2]}};
        m_ab        = (rep_a == rep_b);
        m_ac        = (rep_a == rep_c);
        m_bc        = (rep_b == rep_c);
        vote_word   = m_ac ? rep_a : rep_b;
        vote_err    = {~(m_ac | m_bc), ~(m_ab | m_bc), ~(m_ab | m_ac)};
        vote_uncorr = ~(m_ab | m_ac | m_bc);
    end

    // Acknowledge is only honoured while a request is outstanding
    assign ack_eff = resync_ack & resync_req;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid     <= 1'b0;
            out_word      <= '0;
            out_err       <= '0;
            out_uncorr    <= 1'b0;
            resync_req    <= 1'b0;
            sticky_uncorr <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_word   <= vote_word;
                out_err    <= vote_err;
                out_uncorr <= vote_uncorr;
            end
            resync_req <= ack_eff ? 1'b0 : (|failed);
            if (cnt_clr) begin
                sticky_uncorr <= 1'b0;
            end else if (in_valid && vote_uncorr) begin
                sticky_uncorr <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < REPLICAS; i++) begin : g_trk
        tmr_replica_tracker #(
            .THRESH (THRESH),
            .CNT_W  (CNT_W)
        ) u_trk (
            .clk     (clk),
            .resetn  (resetn),
            .vote_en (in_valid),
            .err     (vote_err[i]),
            .ack     (ack_eff),
            .cnt_clr (cnt_clr),
            .failed  (failed[i]),
            .err_cnt (err_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Bench for tmr_vote_monitor: directed scenarios plus randomized traffic, two
// parameterisations checked every cycle against a behavioural model.
module tb_tmr_vote_monitor;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic [31:0] in_a, in_b, in_c;
    logic [2:0]  err_inject;
    logic        resync_ack;
    logic        cnt_clr;

    logic        o_valid0, o_uncorr0, o_req0, o_sticky0;
    logic [31:0] o_word0;
    logic [2:0]  o_err0, o_failed0;
    logic [47:0] o_cnt0;

    logic        o_valid1, o_uncorr1, o_req1, o_sticky1;
    logic [7:0]  o_word1;
    logic [2:0]  o_err1, o_failed1;
    logic [5:0]  o_cnt1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tmr_vote_monitor #(.WIDTH(32), .THRESH(4), .CNT_W(16)) dut0 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .err_inject(err_inject),
        .out_valid(o_valid0), .out_word(o_word0), .out_err(o_err0), .out_uncorr(o_uncorr0),
        .failed(o_failed0), .resync_req(o_req0), .resync_ack(resync_ack), .cnt_clr(cnt_clr),
        .err_cnt(o_cnt0), .sticky_uncorr(o_sticky0)
    );

    tmr_vote_monitor #(.WIDTH(8), .THRESH(1), .CNT_W(2)) dut1 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_c(in_c[7:0]), .err_inject(err_inject),
        .out_valid(o_valid1), .out_word(o_word1), .out_err(o_err1), .out_uncorr(o_uncorr1),
        .failed(o_failed1), .resync_req(o_req1), .resync_ack(resync_ack), .cnt_clr(cnt_clr),
        .err_cnt(o_cnt1), .sticky_uncorr(o_sticky1)
    );

    // Reference model state, one slot per instance
    int unsigned     mt[2]   = '{4, 1};
    int unsigned     mcw[2]  = '{16, 2};
    longint unsigned mmax[2] = '{65535, 3};
    bit              m_valid[2], m_uncorr[2], m_sticky[2], m_req[2];
    logic [31:0]     m_word[2];
    logic [2:0]      m_err[2];
    int unsigned     m_run[2][3];
    bit              m_failed[2][3];
    longint unsigned m_cnt[2][3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0; m_uncorr[k] = 0; m_sticky[k] = 0; m_req[k] = 0;
            m_word[k] = '0; m_err[k] = '0;
            for (int i = 0; i < 3; i++) begin
                m_run[k][i] = 0; m_failed[k][i] = 0; m_cnt[k][i] = 0;
            end
        end
    endtask

    task automatic model_step(input int k);
        logic [31:0] mask, word;
        logic [31:0] r[3];
        logic [2:0]  err;
        bit          unc, ackeff, anyf;
        mask = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        r[0] = (in_a ^ {32{err_inject[0]}}) & mask;
        r[1] = (in_b ^ {32{err_inject[1]}}) & mask;
        r[2] = (in_c ^ {32{err_inject[2]}}) & mask;
        unc  = (r[0] != r[1]) && (r[0] != r[2]) && (r[1] != r[2]);
        if (r[0] == r[1] || r[0] == r[2]) word = r[0];
        else word = r[1];
        for (int i = 0; i < 3; i++) err[i] = unc ? 1'b1 : (r[i] != word);

        ackeff = resync_ack && m_req[k];
        anyf   = m_failed[k][0] || m_failed[k][1] || m_failed[k][2];
        m_req[k] = ackeff ? 1'b0 : anyf;
        for (int i = 0; i < 3; i++) begin
            if (m_failed[k][i]) begin
                if (ackeff) begin
                    m_failed[k][i] = 0;
                    m_run[k][i] = 0;
                end
            end else if (in_valid) begin
                if (err[i]) begin
                    m_run[k][i]++;
                    if (m_run[k][i] >= mt[k]) m_failed[k][i] = 1;
                end else begin
                    m_run[k][i] = 0;
                end
            end
            if (cnt_clr) m_cnt[k][i] = 0;
            else if (in_valid && err[i] && m_cnt[k][i] < mmax[k]) m_cnt[k][i]++;
        end
        if (cnt_clr) m_sticky[k] = 0;
        else if (in_valid && unc) m_sticky[k] = 1;
        m_valid[k] = in_valid;
        if (in_valid) begin
            m_word[k] = word; m_err[k] = err; m_uncorr[k] = unc;
        end
    endtask

    task automatic check_all(input int k);
        logic [63:0] ecnt;
        logic [2:0]  ef;
        ecnt = '0;
        for (int i = 0; i < 3; i++) ecnt |= 64'(m_cnt[k][i]) << (i * mcw[k]);
        ef = {m_failed[k][2], m_failed[k][1], m_failed[k][0]};
        if (k == 0) begin
            check("valid0",  64'(o_valid0),  64'(m_valid[0]));
            check("word0",   64'(o_word0),   64'(m_word[0]));
            check("err0",    64'(o_err0),    64'(m_err[0]));
            check("uncorr0", 64'(o_uncorr0), 64'(m_uncorr[0]));
            check("failed0", 64'(o_failed0), 64'(ef));
            check("req0",    64'(o_req0),    64'(m_req[0]));
            check("cnt0",    64'(o_cnt0),    ecnt);
            check("sticky0", 64'(o_sticky0), 64'(m_sticky[0]));
        end else begin
            check("valid1",  64'(o_valid1),  64'(m_valid[1]));
            check("word1",   64'(o_word1),   64'(m_word[1]));
            check("err1",    64'(o_err1),    64'(m_err[1]));
            check("uncorr1", 64'(o_uncorr1), 64'(m_uncorr[1]));
            check("failed1", 64'(o_failed1), 64'(ef));
            check("req1",    64'(o_req1),    64'(m_req[1]));
            check("cnt1",    64'(o_cnt1),    ecnt);
            check("sticky1", 64'(o_sticky1), 64'(m_sticky[1]));
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 ns later
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all(0);
        check_all(1);
    endtask

    task automatic set_all(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        in_a = a; in_b = b; in_c = c;
    endtask

    initial begin
        logic [31:0] base;
        resetn = 1'b0; in_valid = 1'b0; err_inject = '0; resync_ack = 1'b0; cnt_clr = 1'b0;
        set_all(32'h0, 32'h0, 32'h0);
        model_reset();
        #3;
        check_all(0);
        check_all(1);
        @(negedge clk);
        resetn = 1'b1;

        // Clean vote
        in_valid = 1'b1;
        set_all(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        cycle();
        check("t1_valid", 64'(o_valid0), 64'd1);
        check("t1_word",  64'(o_word0),  64'hDEADBEEF);
        check("t1_err",   64'(o_err0),   64'd0);
        check("t1_cnt",   64'(o_cnt0),   64'd0);

        // Single corrupted replica
        set_all(32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
        cycle();
        check("t2_word",   64'(o_word0),        64'hDEADBEEF);
        check("t2_err",    64'(o_err0),         64'b010);
        check("t2_cnt1",   64'(o_cnt0[31:16]),  64'd1);
        check("t2_failed", 64'(o_failed0),      64'd0);

        // Repeated injected fault on replica 2 reaches FAILED, then resync
        set_all(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        err_inject = 3'b100;
        for (int n = 0; n < 4; n++) begin
            cycle();
            check("t3_failed_run", 64'(o_failed0), (n == 3) ? 64'b100 : 64'd0);
        end
        check("t3_req_lag", 64'(o_req0), 64'd0);
        err_inject = 3'b000;
        cycle();
        check("t3_req", 64'(o_req0), 64'd1);
        resync_ack = 1'b1;
        cycle();
        resync_ack = 1'b0;
        check("t3_ack_failed", 64'(o_failed0), 64'd0);
        check("t3_ack_req",    64'(o_req0),    64'd0);

        // Uncorrectable vote and counter clear
        set_all(32'd1, 32'd2, 32'd3);
        cycle();
        check("t4_word",   64'(o_word0),    64'd2);
        check("t4_err",    64'(o_err0),     64'b111);
        check("t4_uncorr", 64'(o_uncorr0),  64'd1);
        check("t4_sticky", 64'(o_sticky0),  64'd1);
        set_all(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        check("t4_clr_sticky", 64'(o_sticky0), 64'd0);
        check("t4_clr_cnt",    64'(o_cnt0),    64'd0);

        // Saturation of the 2-bit counter, then clear racing an increment
        set_all(32'h0, 32'hDEADBEEF, 32'hDEADBEEF);
        for (int n = 0; n < 5; n++) cycle();
        check("t5_sat", 64'(o_cnt1[1:0]), 64'd3);
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        check("t5_clr_wins", 64'(o_cnt1[1:0]), 64'd0);

        // Clear any FAILED replicas, then SUSPECT with idle gaps and async reset
        set_all(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        resync_ack = 1'b1;
        for (int n = 0; n < 3; n++) cycle();
        resync_ack = 1'b0;
        set_all(32'hDEADBEEF, 32'hDEADBEEF, 32'h1);
        cycle();
        in_valid = 1'b0;
        for (int n = 0; n < 4; n++) cycle();
        in_valid = 1'b1;
        cycle();
        cycle();
        check("t6_no_adv", 64'(o_failed0), 64'd0);
        in_valid = 1'b0;
        cycle();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        model_reset();
        check_all(0);
        check_all(1);
        check("t6_rst_cnt", 64'(o_cnt0), 64'd0);
        #2;
        resetn = 1'b1;
        in_valid = 1'b1;
        cycle();
        cycle();
        check("t6_restart_failed", 64'(o_failed0), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            base = $urandom;
            in_a = ($urandom_range(0, 5) == 0) ? $urandom : base;
            in_b = ($urandom_range(0, 5) == 0) ? $urandom : base;
            in_c = ($urandom_range(0, 5) == 0) ? $urandom : base;
            if ($urandom_range(0, 9) == 0) in_c = base ^ (32'h1 << $urandom_range(8, 31));
            in_valid   = ($urandom_range(0, 4) != 0);
            err_inject = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
            resync_ack = ($urandom_range(0, 3) == 0);
            cnt_clr    = ($urandom_range(0, 49) == 0);
            if (n == 1500) begin
                @(negedge clk);
                resetn = 1'b0;
                #1;
                model_reset();
                check_all(0);
                check_all(1);
                #2;
                resetn = 1'b1;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
